mem_stage_sram_ctrl: RTL and testbench

Memory-stage consumer of the EXE/MEM pipeline register outputs (MEM_R_EN, MEM_W_EN, ALU_result, ST_val). It performs 32-bit loads and stores against an external 16-bit asynchronous SRAM as two halfword transfers. While an access is in flight it holds ready low. The top level drives the pipeline freeze from !ready, so the EXE/MEM register and upstream stages hold until the access completes.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 14 +
 rtl/mem_stage_sram_ctrl_if.sv | 30 +++
 rtl/mem_stage_sram_ctrl_sram_wait_counter.sv | 27 ++
 rtl/mem_stage_sram_ctrl.sv | 116 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM encoding and
// the default byte address at which SRAM word 0 is mapped.
package mem_stage_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline request/response and SRAM pad signals of the memory stage.
// The slave modport is the controller; the master modport is its environment.
interface mem_stage_sram_ctrl_if #(
  parameter int ADDR_W = 18
) ();

  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       ALU_result;
  logic [31:0]       ST_val;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       SRAM_DQ_out;
  logic [15:0]       SRAM_DQ_in;
  logic              SRAM_DQ_oe;
  logic              SRAM_WE_N;
  logic              SRAM_OE_N;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    output read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, SRAM_DQ_in,
    input  read_data, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// Loadable down-counter that flags the final cycle of an SRAM access phase.
// It stops at zero, so last stays high until the next load.
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: turns 32-bit pipeline loads/stores into two halfword accesses
// on a 16-bit asynchronous SRAM, holding ready low until the access completes.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input logic                 clk,
  input logic                 rst,
  mem_stage_sram_ctrl_if.slave bus
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic              req;
  logic              cnt_load;
  logic              cnt_last;
  logic [31:0]       offset;
  logic [ADDR_W-2:0] word_next;
  logic [ADDR_W-2:0] word_q;
  logic [15:0]       data_hi_q;
  logic              is_write;
  logic [31:0]       read_data_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       dq_out_q;
  logic              unused_offset_bits;

  assign req       = bus.MEM_R_EN | bus.MEM_W_EN;
  assign offset    = bus.ALU_result - 32'(BASE_ADDR);
  // Byte offset to word index; upper bits drop so out-of-range addresses wrap.
  assign word_next = offset[ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  sram_wait_counter #(.W(CW)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (CNT_INIT),
    .last       (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    case (state)
      IDLE: if (req) begin
        next_state = LOW;
        cnt_load   = 1'b1;
      end
      LOW: if (cnt_last) begin
        next_state = HIGH;
        cnt_load   = 1'b1;
      end
      HIGH: if (cnt_last) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address and write data are registered one phase ahead so they are stable
  // for the whole halfword access and hold their value between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q      <= '0;
      data_hi_q   <= '0;
      is_write    <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          word_q      <= word_next;
          data_hi_q   <= bus.ST_val[31:16];
          is_write    <= bus.MEM_W_EN;
          sram_addr_q <= {word_next, 1'b0};
          dq_out_q    <= bus.ST_val[15:0];
        end
        LOW: if (cnt_last) begin
          if (!is_write) read_data_q[15:0] <= bus.SRAM_DQ_in;
          sram_addr_q <= {word_q, 1'b1};
          dq_out_q    <= data_hi_q;
        end
        HIGH: if (cnt_last && !is_write) read_data_q[31:16] <= bus.SRAM_DQ_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ready      = (state == DONE) || (state == IDLE && !req);
    bus.SRAM_WE_N  = 1'b1;
    bus.SRAM_OE_N  = 1'b1;
    bus.SRAM_DQ_oe = 1'b0;
    if (state == LOW || state == HIGH) begin
      bus.SRAM_WE_N  = !is_write;
      bus.SRAM_DQ_oe = is_write;
      bus.SRAM_OE_N  = is_write;
    end
  end

  assign bus.SRAM_ADDR   = sram_addr_q;
  assign bus.SRAM_DQ_out = dq_out_q;
  assign bus.read_data   = read_data_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural SRAM and a
// scoreboard of expected read_data values checked in each DONE cycle.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.ADDR_W(18)) bus ();

  mem_stage_sram_ctrl #(
    .ADDR_W      (18),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: commits the pad data on every clock edge with WE_N low.
  logic [15:0] sram [0:15];
  int          we_cycles = 0;

  assign bus.SRAM_DQ_in = bus.SRAM_OE_N ? 16'h0000 : sram[bus.SRAM_ADDR[3:0]];

  always @(posedge clk) begin
    if (!rst && !bus.SRAM_WE_N) begin
      sram[bus.SRAM_ADDR[3:0]] <= bus.SRAM_DQ_out;
      we_cycles <= we_cycles + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd = 32'h0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'(o[18:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(bus.SRAM_ADDR), 32'h0);
    chk({tag, "_dq"}, 32'(bus.SRAM_DQ_out), 32'h0);
    chk({tag, "_strobes"}, {29'h0, bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_DQ_oe}, 32'b110);
    chk({tag, "_rdata"}, bus.read_data, 32'h0);
  endtask

  // Issues one request at a negedge and follows it through to its DONE cycle.
  task automatic access(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int stall;
    int we0;
    logic [31:0] exp;
    @(negedge clk);
    we0 = we_cycles;
    bus.MEM_R_EN   = r;
    bus.MEM_W_EN   = w;
    bus.ALU_result = addr;
    bus.ST_val     = data;
    if (w) begin
      ref_mem[word_of(addr)] = data;
    end else begin
      exp_rd = ref_mem.exists(word_of(addr)) ? ref_mem[word_of(addr)] : 32'h0;
    end
    exp_q.push_back(exp_rd);
    #1;
    stall = 0;
    while (!bus.ready && stall < 20) begin
      stall++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall"}, 32'(stall), 32'd5);
    chk({tag, "_we_cycles"}, 32'(we_cycles - we0), w ? 32'd4 : 32'd0);
    chk({tag, "_done_strobes"}, {30'h0, bus.SRAM_WE_N, bus.SRAM_OE_N}, 32'b11);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_rdata"}, bus.read_data, exp);
    end
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_result = 32'h0;
    bus.ST_val     = 32'h0;
    #12;
    check_reset_outputs("reset");
    chk("reset_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle cycles");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {28'h0, bus.ready, bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_DQ_oe}, 32'b1110);
    end

    $display("[TB] store then load");
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "store1028");
    chk("sram2", 32'(sram[2]), 32'h0000BEEF);
    chk("sram3", 32'(sram[3]), 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1028, 32'h0, "load1028");
    @(negedge clk);
    chk("rdata_held", bus.read_data, 32'hDEADBEEF);

    $display("[TB] back-to-back store/load");
    access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, "store1032");
    access(1'b1, 1'b0, 32'd1032, 32'h0, "load1032");
    chk("sram4", 32'(sram[4]), 32'h0000F00D);
    chk("sram5", 32'(sram[5]), 32'h0000CAFE);

    $display("[TB] both enables");
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, "both1024");
    chk("sram0", 32'(sram[0]), 32'h00005678);
    chk("sram1", 32'(sram[1]), 32'h00001234);

    $display("[TB] reset during HIGH of a store");
    @(negedge clk);
    bus.MEM_W_EN   = 1'b1;
    bus.ALU_result = 32'd1024;
    bus.ST_val     = 32'hAAAA5555;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_high", {15'h0, bus.SRAM_ADDR[0], 15'h0, bus.SRAM_WE_N}, {15'h0, 1'b1, 16'h0});
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    bus.MEM_W_EN = 1'b0;
    exp_rd = 32'h0;
    ref_mem[0] = 32'h12345555;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(bus.ready), 32'd1);
    chk("sram0_partial", 32'(sram[0]), 32'h00005555);
    chk("sram1_untouched", 32'(sram[1]), 32'h00001234);
    access(1'b1, 1'b0, 32'd1024, 32'h0, "load_after_reset");
    access(1'b1, 1'b0, 32'd1024 + (32'd1 << 19), 32'h0, "load_wrap");
    access(1'b1, 1'b0, 32'd1031, 32'h0, "load_lowbits");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
